mem_responder: RTL and testbench

- Unified instruction/data memory that sits on the far side of the CPU's instruction bus and data memory bus.
- Serves IF-stage instruction fetches on a read-only port.
- Serves MEM-stage loads and stores on a shared bidirectional data bus, with a fixed one-cycle read latency.
- Owns bus turnaround on Memory_databus so the CPU and the memory never drive it at the same time.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 62 ++++++
 rtl/mem_responder.sv | 67 ++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, types and helpers for the unified instruction/data memory.
package mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam word_t OOR_READ_VALUE = 16'h0000;

    // Byte address to word index; the byte-select bit plays no part in access.
    function automatic logic [ADDR_W-2:0] word_index(input addr_t addr);
        return addr[ADDR_W-1:1];
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, a synchronous data read port and a
// synchronous fetch read port, both read-before-write, with out-of-range masking.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W:0]    DEPTH_L  = DEPTH_WORDS[IDX_W:0];
    localparam logic [DATA_W-1:0] OOR_WORD = DATA_W'(OOR_READ_VALUE);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] data_idx;
    logic [IDX_W-1:0] fetch_idx;
    logic             data_in_range;
    logic             fetch_in_range;
    logic             unused_addr_lsb;

    assign data_idx  = data_addr[ADDR_W-1:1];
    assign fetch_idx = fetch_addr[ADDR_W-1:1];

    // Compare one bit wider so DEPTH_WORDS == 2^IDX_W does not wrap to zero.
    assign data_in_range  = {1'b0, data_idx}  < DEPTH_L;
    assign fetch_in_range = {1'b0, fetch_idx} < DEPTH_L;

    assign unused_addr_lsb = data_addr[0] ^ fetch_addr[0];

    // Contents survive reset; writes are only blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && we && data_in_range) begin
            mem[data_idx[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_data <= '0;
            rd_data    <= '0;
        end else begin
            fetch_data <= fetch_in_range ? mem[fetch_idx[AW-1:0]] : OOR_WORD;
            if (rd_en) begin
                rd_data <= data_in_range ? mem[data_idx[AW-1:0]] : OOR_WORD;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the CPU instruction and data buses; owns data-bus turnaround.
// Optional sticky misalignment flag mem_err when MEM_RESP_ALIGN_CHECK_EN is defined.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Instruction_addressbus,
    output logic [DATA_W-1:0] Instruction_databus,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    inout  wire  [DATA_W-1:0] Memory_databus,
    input  logic              Memory_writemode
`ifdef MEM_RESP_ALIGN_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    mem_array #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (Memory_writemode),
        .rd_en      (!Memory_writemode),
        .data_addr  (Memory_addressbus),
        .wr_data    (Memory_databus),
        .rd_data    (rd_data),
        .fetch_addr (Instruction_addressbus),
        .fetch_data (Instruction_databus)
    );

    // Bus ownership: the CPU owns Memory_databus whenever Memory_writemode is high.
    // rd_valid marks that rd_data holds the result of the load sampled at the last
    // edge; the memory drives only while rd_valid is set and writemode is low, so a
    // store after a load releases the bus combinationally and a load after a store
    // leaves exactly one undriven cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= !Memory_writemode;
        end
    end

    assign Memory_databus = (rd_valid && !Memory_writemode) ? rd_data : {DATA_W{1'bz}};

`ifdef MEM_RESP_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (Memory_addressbus[0] || Instruction_addressbus[0]) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against an array/queue reference model.
// Covers MEM_RESP_ALIGN_CHECK_EN when the macro is defined for the build.
module tb_mem_responder;

    localparam int DEPTH = 32;
    // A pull-up on the shared bus makes the undriven state observable.
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] iaddr;
    logic [11:0] daddr;
    logic        wm;
    logic        cpu_drive;
    logic [15:0] cpu_data;
    logic [15:0] Instruction_databus;
    wire  [15:0] Memory_databus;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic        mem_err;
    logic        exp_err;
`endif

    always #5 clk = ~clk;

    pullup (Memory_databus);
    assign Memory_databus = cpu_drive ? cpu_data : 16'hzzzz;

    mem_responder #(
        .ADDR_W      (12),
        .DATA_W      (16),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .Instruction_addressbus (iaddr),
        .Instruction_databus    (Instruction_databus),
        .Memory_addressbus      (daddr),
        .Memory_databus         (Memory_databus),
        .Memory_writemode       (wm)
`ifdef MEM_RESP_ALIGN_CHECK_EN
        ,
        .mem_err                (mem_err)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    logic [15:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic [15:0] exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; applies one bus cycle and returns at the next falling edge.
    task automatic step(input logic w, input logic [11:0] da, input logic [15:0] wd,
                        input logic [11:0] ia);
        int          dw;
        int          iw;
        logic [15:0] exp_instr;
        bit          instr_known;
        wm        = w;
        daddr     = da;
        iaddr     = ia;
        cpu_drive = w;
        cpu_data  = wd;
        #1;
        if (w)
            check("bus_store", Memory_databus, wd);
        else if (exp_q.size() != 0)
            check("bus_load", Memory_databus, exp_q.pop_front());
        else
            check("bus_turnaround", Memory_databus, BUS_IDLE);
        @(posedge clk);
        dw = int'(da) / 2;
        iw = int'(ia) / 2;
        if (iw < DEPTH) begin
            exp_instr   = model_mem[iw];
            instr_known = known[iw];
        end else begin
            exp_instr   = 16'h0000;
            instr_known = 1'b1;
        end
        if (w) begin
            exp_q.delete();
            if (dw < DEPTH) begin
                model_mem[dw] = wd;
                known[dw]     = 1'b1;
            end
        end else begin
            exp_q.push_back(dw < DEPTH ? model_mem[dw] : 16'h0000);
        end
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if (da[0] || ia[0]) exp_err = 1'b1;
`endif
        #1;
        if (instr_known) check("instr_fetch", Instruction_databus, exp_instr);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        check("mem_err", {15'd0, mem_err}, {15'd0, exp_err});
`endif
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        wm        = 1'b0;
        cpu_drive = 1'b0;
        #1;
        if (exp_q.size() != 0) check("pre_reset_drive", Memory_databus, exp_q[0]);
        rst_n = 1'b0;
        #1;
        check("reset_bus_release", Memory_databus, BUS_IDLE);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus", Memory_databus, BUS_IDLE);
        check("reset_instr", Instruction_databus, 16'h0000);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        exp_err = 1'b0;
        check("reset_mem_err", {15'd0, mem_err}, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        wm        = 1'b0;
        cpu_drive = 1'b0;
        cpu_data  = 16'h0000;
        daddr     = 12'h000;
        iaddr     = 12'h000;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        exp_err   = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // Fill every implemented word so later reads have defined expectations.
        for (int w = 0; w < DEPTH; w++)
            step(1'b1, 12'(w * 2), 16'($urandom), 12'(w > 0 ? (w - 1) * 2 : 0));

        // Store then load with the one undriven turnaround cycle.
        step(1'b1, 12'h010, 16'hFFFD, 12'h000);
        step(1'b0, 12'h010, 16'h0000, 12'h000);
        step(1'b0, 12'h000, 16'h0000, 12'h000);

        // Alternating store/load on one word.
        for (int i = 0; i < 10; i++)
            step((i % 2) == 0, 12'h020, 16'($urandom), 12'h020);

        // Store and fetch of the same word at one edge.
        step(1'b1, 12'h004, 16'h4444, 12'h000);
        step(1'b1, 12'h004, 16'h5555, 12'h004);
        step(1'b0, 12'h000, 16'h0000, 12'h004);

        // Out of range and last in-range word.
        step(1'b1, 12'h040, 16'h1234, 12'h040);
        step(1'b0, 12'h040, 16'h0000, 12'h040);
        step(1'b0, 12'h000, 16'h0000, 12'h000);
        step(1'b1, 12'h03E, 16'hBEEF, 12'h000);
        step(1'b0, 12'h03E, 16'h0000, 12'h03E);
        step(1'b0, 12'h000, 16'h0000, 12'h000);

        // Misaligned load still uses the word index; the error flag is sticky.
        step(1'b1, 12'h010, 16'hABCD, 12'h000);
        step(1'b0, 12'h011, 16'h0000, 12'h000);
        for (int i = 0; i < 3; i++)
            step(1'b0, 12'h000, 16'h0000, 12'h000);

        // Randomized traffic, including misaligned and out-of-range addresses.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'h04F)),
                 16'($urandom), 12'($urandom_range(0, 12'h04F)));

        // Reset while the memory drives the bus; the array keeps its contents.
        step(1'b1, 12'h012, 16'h0F0F, 12'h000);
        step(1'b0, 12'h012, 16'h0000, 12'h000);
        do_reset();
        step(1'b0, 12'h012, 16'h0000, 12'h012);
        step(1'b0, 12'h000, 16'h0000, 12'h000);
        step(1'b0, 12'h000, 16'h0000, 12'h000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
